// File: rtl/sysid_pkg.sv
// Shared definitions for the sysid checker: FSM state encoding, the default
// build timestamp and the two sysid slave word addresses.
package sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_READ_ID    = 3'd1,
    S_READ_TS    = 3'd2,
    S_COMPARE    = 3'd3,
    S_RETRY_WAIT = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [31:0] DEFAULT_TIMESTAMP = 32'd1513181670;

  localparam logic ID_ADDR = 1'b0;
  localparam logic TS_ADDR = 1'b1;

endpackage

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID and timestamp words from a sysid slave,
// compares them against the expected build values and retries a bounded
// number of times before reporting pass/fail.
//
// Ports:
//   clock, reset        single clock; asynchronous active-high reset
//   start               re-run request, honoured only in IDLE or DONE
//   sysid_address       slave word select (0 = ID, 1 = timestamp)
//   sysid_readdata      slave read data
//   id_value            last captured ID word
//   timestamp_value     last captured timestamp word
//   busy, done, pass    run status
//   mismatch_id/_ts     result flags of the last compare
//   retry_count         re-reads consumed in the current run
//
// state        | meaning
// -------------+------------------------------------------------------
// S_IDLE       | after reset; leaves on auto-start or start
// S_READ_ID    | address 0 held READ_LATENCY+1 cycles, ID captured last
// S_READ_TS    | address 1 held READ_LATENCY+1 cycles, TS captured last
// S_COMPARE    | one cycle; registers mismatch flags, decides outcome
// S_RETRY_WAIT | RETRY_GAP idle cycles before re-reading
// S_DONE       | result held until start or reset
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_TIMESTAMP,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned RETRY_GAP          = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        mismatch_id,
  output logic        mismatch_ts,
  output logic [1:0]  retry_count
);

  // Counter reloads: a zero count marks the last cycle of a phase, so a
  // phase of N cycles loads N-1.
  localparam logic [7:0] LAT_LOAD  = 8'(READ_LATENCY);
  localparam logic [7:0] GAP_LOAD  = 8'(RETRY_GAP - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        auto_start, auto_start_n;
  logic [31:0] id_n, ts_n;
  logic        pass_n, mismatch_id_n, mismatch_ts_n;
  logic [1:0]  retry_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= 8'd0;
      auto_start      <= 1'b1;
      id_value        <= 32'd0;
      timestamp_value <= 32'd0;
      pass            <= 1'b0;
      mismatch_id     <= 1'b0;
      mismatch_ts     <= 1'b0;
      retry_count     <= 2'd0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      auto_start      <= auto_start_n;
      id_value        <= id_n;
      timestamp_value <= ts_n;
      pass            <= pass_n;
      mismatch_id     <= mismatch_id_n;
      mismatch_ts     <= mismatch_ts_n;
      retry_count     <= retry_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    auto_start_n  = auto_start;
    id_n          = id_value;
    ts_n          = timestamp_value;
    pass_n        = pass;
    mismatch_id_n = mismatch_id;
    mismatch_ts_n = mismatch_ts;
    retry_n       = retry_count;

    case (state)
      S_IDLE: begin
        if (auto_start || start) begin
          auto_start_n = 1'b0;
          cnt_n        = LAT_LOAD;
          state_n      = S_READ_ID;
        end
      end
      S_READ_ID: begin
        if (cnt == 8'd0) begin
          id_n    = sysid_readdata;
          cnt_n   = LAT_LOAD;
          state_n = S_READ_TS;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_READ_TS: begin
        if (cnt == 8'd0) begin
          ts_n    = sysid_readdata;
          state_n = S_COMPARE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_COMPARE: begin
        mismatch_id_n = (id_value != EXPECTED_ID);
        mismatch_ts_n = (timestamp_value != EXPECTED_TIMESTAMP);
        if (!mismatch_id_n && !mismatch_ts_n) begin
          pass_n  = 1'b1;
          state_n = S_DONE;
        end else if (retry_count < RETRY_MAX) begin
          retry_n = retry_count + 2'd1;
          cnt_n   = GAP_LOAD;
          state_n = S_RETRY_WAIT;
        end else begin
          pass_n  = 1'b0;
          state_n = S_DONE;
        end
      end
      S_RETRY_WAIT: begin
        if (cnt == 8'd0) begin
          cnt_n   = LAT_LOAD;
          state_n = S_READ_ID;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_DONE: begin
        // Captured words are kept until the next read overwrites them.
        if (start) begin
          pass_n        = 1'b0;
          mismatch_id_n = 1'b0;
          mismatch_ts_n = 1'b0;
          retry_n       = 2'd0;
          cnt_n         = LAT_LOAD;
          state_n       = S_READ_ID;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign sysid_address = (state == S_READ_TS) ? TS_ADDR : ID_ADDR;
  assign busy          = (state == S_READ_ID) || (state == S_READ_TS) ||
                         (state == S_COMPARE) || (state == S_RETRY_WAIT);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a default-parameter instance with a
// configurable zero-latency slave, and a READ_LATENCY=2 instance with a
// slave whose data lags the address by two cycles.
module tb_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1513181670;
  localparam logic [31:0] ID_LAT  = 32'h1234_5678;
  localparam logic [31:0] TS_LAT  = 32'hCAFE_F00D;

  logic        clock;
  logic        reset, start;
  logic        addr;
  logic [31:0] rdata, id_v, ts_v;
  logic        busy, done, pass, mid, mts;
  logic [1:0]  retry;

  logic        rst_l;
  logic        addr_l;
  logic [31:0] rdata_l, id_l, ts_l;
  logic        busy_l, done_l, pass_l, mid_l, mts_l;
  logic [1:0]  retry_l;
  logic        a1, a2;

  logic id_bad, ts_bad;
  int   checks = 0;
  int   errors = 0;

  sysid_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .sysid_address(addr), .sysid_readdata(rdata),
    .id_value(id_v), .timestamp_value(ts_v),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_id(mid), .mismatch_ts(mts), .retry_count(retry)
  );

  sysid_checker #(
    .EXPECTED_ID(ID_LAT), .EXPECTED_TIMESTAMP(TS_LAT), .READ_LATENCY(2)
  ) dut_lat (
    .clock(clock), .reset(rst_l), .start(1'b0),
    .sysid_address(addr_l), .sysid_readdata(rdata_l),
    .id_value(id_l), .timestamp_value(ts_l),
    .busy(busy_l), .done(done_l), .pass(pass_l),
    .mismatch_id(mid_l), .mismatch_ts(mts_l), .retry_count(retry_l)
  );

  assign rdata = (addr == 1'b0) ? (id_bad ? 32'd5 : 32'd0)
                                : (ts_bad ? 32'd1 : TS_GOOD);

  initial begin a1 = 1'b0; a2 = 1'b0; end
  always @(posedge clock) begin
    a1 <= addr_l;
    a2 <= a1;
  end
  assign rdata_l = (a2 == 1'b0) ? ID_LAT : TS_LAT;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; rst_l = 1'b1; start = 1'b0; id_bad = 1'b0; ts_bad = 1'b0;
    step(2);
    chk("rst_addr", addr, 0);
    chk("rst_id", id_v, 0);
    chk("rst_ts", ts_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mid", mid, 0);
    chk("rst_mts", mts, 0);
    chk("rst_retry", retry, 0);
    chk("rst_l_busy", busy_l, 0);

    // auto-start on both instances
    reset = 1'b0; rst_l = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 1) begin chk("auto_busy", busy, 1); chk("auto_addr_id", addr, 0); end
      if (k == 2) chk("auto_addr_ts", addr, 1);
      if (k == 3) begin chk("auto_cmp_done", done, 0); chk("lat_addr_id", addr_l, 0); end
      if (k == 4) begin
        chk("auto_done", done, 1);
        chk("auto_pass", pass, 1);
        chk("auto_retry", retry, 0);
        chk("auto_busy_lo", busy, 0);
        chk("auto_ts", ts_v, TS_GOOD);
        chk("lat_addr_ts", addr_l, 1);
      end
      if (k == 7) chk("lat_done_early", done_l, 0);
      if (k == 8) begin
        chk("lat_done", done_l, 1);
        chk("lat_pass", pass_l, 1);
        chk("lat_id", id_l, ID_LAT);
        chk("lat_ts", ts_l, TS_LAT);
      end
    end

    // rerun from DONE; start during READ_TS is dropped
    start = 1'b1; step(1); start = 1'b0;
    chk("rerun_done_clr", done, 0);
    chk("rerun_busy", busy, 1);
    step(1);
    chk("rerun_addr_ts", addr, 1);
    start = 1'b1; step(1); start = 1'b0;
    chk("rerun_cmp_done", done, 0);
    step(1);
    chk("rerun_done", done, 1);
    chk("rerun_pass", pass, 1);
    step(3);
    chk("ignored_done", done, 1);
    chk("ignored_busy", busy, 0);

    // timestamp permanently wrong: three retries, 4-cycle gaps, then fail
    ts_bad = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      if (k == 1) begin start = 1'b0; chk("ts_retry0", retry, 0); end
      if (k == 4) begin
        chk("ts_retry1", retry, 1);
        chk("ts_mts1", mts, 1);
        chk("ts_mid1", mid, 0);
        chk("ts_busy_gap", busy, 1);
      end
      if (k == 7) chk("ts_gap_addr", addr, 0);
      if (k == 9) chk("ts_reread_addr", addr, 1);
      if (k == 10) chk("ts_retry1_hold", retry, 1);
      if (k == 11) chk("ts_retry2", retry, 2);
      if (k == 17) chk("ts_retry2_hold", retry, 2);
      if (k == 18) chk("ts_retry3", retry, 3);
      if (k == 24) chk("ts_done_early", done, 0);
      if (k == 25) begin
        chk("ts_done", done, 1);
        chk("ts_pass", pass, 0);
        chk("ts_mts", mts, 1);
        chk("ts_mid", mid, 0);
        chk("ts_retry_final", retry, 3);
      end
    end
    step(2);
    chk("ts_hold_pass", pass, 0);
    chk("ts_hold_retry", retry, 3);

    // ID wrong on the first read only
    ts_bad = 1'b0; id_bad = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      if (k == 1) begin
        start = 1'b0;
        chk("id_retry_clr", retry, 0);
        chk("id_mts_clr", mts, 0);
        chk("id_ts_hold", ts_v, 32'd1);
      end
      if (k == 2) begin chk("id_first", id_v, 5); id_bad = 1'b0; end
      if (k == 4) begin
        chk("id_retry1", retry, 1);
        chk("id_mid1", mid, 1);
        chk("id_mts1", mts, 0);
      end
      if (k == 10) chk("id_done_early", done, 0);
      if (k == 11) begin
        chk("id_done", done, 1);
        chk("id_pass", pass, 1);
        chk("id_retry", retry, 1);
        chk("id_mid", mid, 0);
        chk("id_value", id_v, 0);
      end
    end

    // reset during RETRY_WAIT
    ts_bad = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      if (k == 1) start = 1'b0;
    end
    chk("rw_busy", busy, 1);
    chk("rw_retry", retry, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_retry", retry, 0);
    chk("arst_mts", mts, 0);
    chk("arst_id", id_v, 0);
    chk("arst_ts", ts_v, 0);
    chk("arst_addr", addr, 0);
    step(2);
    ts_bad = 1'b0;
    reset = 1'b0;
    step(3);
    chk("rst_restart_busy", busy, 1);
    chk("rst_restart_done", done, 0);
    step(1);
    chk("rst_restart_done1", done, 1);
    chk("rst_restart_pass", pass, 1);
    chk("rst_restart_retry", retry, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, is the 32-bit system ID the block expects at sysid address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1513181670, is the 32-bit timestamp the block expects at sysid address 1.
REQ-003 Parameter READ_LATENCY, default 0, range 0..7, is the number of cycles between driving sysid_address and sampling sysid_readdata.
REQ-004 Parameter MAX_RETRIES, default 3, range 0..3, is the number of re-reads after a mismatch before failure is declared.
REQ-005 Parameter RETRY_GAP, default 4, range 1..255, is the number of idle cycles between a failed compare and the next re-read.
REQ-006 Port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: request to re-run the check; sampled only in IDLE or DONE.
REQ-009 Port sysid_address, output, 1 bit: address to the sysid slave (0 = ID, 1 = timestamp).
REQ-010 Port sysid_readdata, input, 32 bits: read data from the sysid slave.
REQ-011 Port id_value, output, 32 bits: last captured ID word.
REQ-012 Port timestamp_value, output, 32 bits: last captured timestamp word.
REQ-013 Port busy, output, 1 bit: high while a check or retry is in progress.
REQ-014 Port done, output, 1 bit: high in DONE.
REQ-015 Port pass, output, 1 bit: high in DONE when both words matched.
REQ-016 Port mismatch_id and mismatch_ts, outputs, 1 bit each: compare result flags from the last compare.
REQ-017 Port retry_count, output, 2 bits: number of retries consumed in the current run.

Function
REQ-018 The FSM states SHALL be IDLE, READ_ID, READ_TS, COMPARE, RETRY_WAIT and DONE.
REQ-019 IDLE SHALL go to READ_ID on the first edge after reset release (auto-start), or when start=1.
REQ-020 READ_ID SHALL drive sysid_address=0 for READ_LATENCY+1 cycles, then capture sysid_readdata into id_value on the last cycle and go to READ_TS.
REQ-021 READ_TS SHALL drive sysid_address=1 for READ_LATENCY+1 cycles, then capture into timestamp_value on the last cycle and go to COMPARE.
REQ-022 sysid_address SHALL be 0 in every state except READ_TS.
REQ-023 COMPARE SHALL take 1 cycle: it registers mismatch_id = (id_value != EXPECTED_ID) and mismatch_ts = (timestamp_value != EXPECTED_TIMESTAMP) with exact 32-bit equality.
REQ-024 COMPARE with both flags clear SHALL go to DONE with pass=1.
REQ-025 COMPARE with any flag set and retry_count < MAX_RETRIES SHALL increment retry_count and go to RETRY_WAIT; with retry_count = MAX_RETRIES it SHALL go to DONE with pass=0.
REQ-026 RETRY_WAIT SHALL idle for RETRY_GAP cycles and then go to READ_ID.
REQ-027 Latency: if start is sampled at edge N, done and pass SHALL be valid after edge N+2*READ_LATENCY+3 when no retry occurs.
REQ-028 busy SHALL be high exactly in READ_ID, READ_TS, COMPARE and RETRY_WAIT.
REQ-029 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-030 start=1 in DONE SHALL clear done, pass, the mismatch flags and retry_count, and go to READ_ID on the same edge; id_value and timestamp_value SHALL hold until recaptured.
REQ-031 DONE SHALL hold all outputs stable until start or reset.

Reset
REQ-032 Reset SHALL force IDLE with the auto-start flag set, sysid_address=0, id_value=0, timestamp_value=0, busy=0, done=0, pass=0, mismatch flags=0 and retry_count=0.
REQ-033 Reset asserted mid-check SHALL abort immediately; the check restarts via auto-start after release.

Structure
REQ-034 Package sysid_pkg SHALL hold the state enum, the default EXPECTED_TIMESTAMP constant and the address constants ID_ADDR=0 and TS_ADDR=1.
REQ-035 The block SHALL be a single module with no sub-modules; the latency/gap counter SHALL be 8 bits wide and shared by the read and retry states.

Verification
REQ-036 Defaults, slave returns 0 at address 0 and 1513181670 at address 1: done and pass are high 3 edges after the first post-reset edge, and retry_count=0.
REQ-037 READ_LATENCY=2, slave data delayed 2 cycles: values are captured correctly and done rises at N+7.
REQ-038 Timestamp word returns 1 permanently: the bench sees 3 retries each separated by 4 idle cycles, then done=1, pass=0, mismatch_ts=1, mismatch_id=0 and retry_count=3.
REQ-039 ID word returns 5 on the first read and 0 afterwards: pass=1 with retry_count=1.
REQ-040 start pulsed during READ_TS is ignored; start pulsed in DONE reruns the check, clears done for 3 cycles and then reasserts it.
REQ-041 reset asserted during RETRY_WAIT: all outputs return to their reset values asynchronously, and the check auto-restarts after release.
